scaler_out_retime: RTL

Output re-timing stage placed directly downstream of the bicubic scaler. It accepts the scaler's sparse pixel stream (`SPARSE_OUT` empty cycles between pixels) and stores each line in a ping-pong line buffer. It then replays every completed line as a contiguous burst of `de_o`, followed by a programmable horizontal blanking interval. The video sink therefore sees a dense, regular line timing regardless of the scaler's output sparseness.

---
 rtl/scaler_out_retime.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/scaler_out_retime.sv
// rtl/scaler_out_retime.sv - ping-pong line buffer replaying sparse scaler lines as dense bursts
// Optional feature macro: SCALER_OUT_RETIME_OVF_EN (sticky ovf_o flag and dropped-line counter)
module scaler_out_retime #(
    parameter int LINE_OUT_SIZE_MAX = 2048,
    parameter int PIXEL_WIDTH       = 12,
    parameter int H_BLANK           = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   ovf_o,
    output logic [15:0]            line_len_o
);

    localparam int          AW         = $clog2(LINE_OUT_SIZE_MAX);
    localparam logic [15:0] LEN_MAX    = 16'(LINE_OUT_SIZE_MAX);
    localparam logic [15:0] BLANK_LAST = 16'(H_BLANK - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_BLANK} state_t;

    // Bank select is the top address bit, so each bank spans a power-of-two region
    logic [PIXEL_WIDTH-1:0] mem [0:(2 << AW)-1];

    logic [1:0]  full;
    logic [15:0] len [2];
    logic        wr_bank;
    logic        rd_bank;
    logic [15:0] wr_cnt;
    logic        hs_d;
    logic        armed;
    logic        line_bad;
    state_t      state;
    logic [15:0] rd_cnt;
    logic [15:0] rd_len;
    logic [15:0] blank_cnt;

    logic        hs_rise;
    logic        wr_full;
    logic        cnt_en;
    logic        wr_en;
    logic        line_close;
    logic        line_accept;
    logic        rd_start;
    logic        rd_done;
    logic [1:0]  full_set;
    logic [1:0]  full_clr;

    // Write-side decode and the set/clear requests for the bank full flags.
    // A pixel that arrives while its target bank is still full cannot be stored,
    // so the whole line is marked bad and dropped when it closes.
    always_comb begin
        hs_rise     = hs_i & ~hs_d;
        wr_full     = full[wr_bank];
        cnt_en      = armed & de_i & ~hs_rise & (wr_cnt < LEN_MAX);
        wr_en       = cnt_en & ~wr_full;
        line_close  = hs_rise & (wr_cnt != 16'd0);
        line_accept = line_close & ~wr_full & ~line_bad;
        rd_start    = (state == ST_IDLE) & full[rd_bank];
        rd_done     = (state == ST_ACTIVE) & (rd_cnt == rd_len - 16'd1);
        full_set    = 2'b00;
        full_clr    = 2'b00;
        if (line_accept) full_set[wr_bank] = 1'b1;
        if (rd_done)     full_clr[rd_bank] = 1'b1;
    end

    // Write side: count pixels of the current line and close it on rising hs_i.
    // After reset, pixels are ignored until blanking is seen, so a line cut by reset is never accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_d     <= 1'b0;
            armed    <= 1'b0;
            wr_cnt   <= 16'd0;
            wr_bank  <= 1'b0;
            line_bad <= 1'b0;
            len[0]   <= 16'd0;
            len[1]   <= 16'd0;
        end else begin
            hs_d <= hs_i;
            if (hs_i) armed <= 1'b1;
            if (hs_rise) begin
                wr_cnt   <= 16'd0;
                line_bad <= 1'b0;
            end else if (cnt_en) begin
                wr_cnt <= wr_cnt + 16'd1;
                if (wr_full) line_bad <= 1'b1;
            end
            if (line_accept) begin
                len[wr_bank] <= wr_cnt;
                wr_bank      <= ~wr_bank;
            end
        end
    end

    // Line storage write port
    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank, wr_cnt[AW-1:0]}] <= di_i;
    end

    // Bank full flags: set by the writer, cleared by the reader, never the same bank in one cycle
    always_ff @(posedge clk) begin
        if (rst) full <= 2'b00;
        else     full <= (full & ~full_clr) | full_set;
    end

    // Read FSM: replay a full bank as one contiguous burst, then H_BLANK cycles of hs_o.
    // Outputs are registered one cycle behind the state, matching the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rd_bank    <= 1'b0;
            rd_cnt     <= 16'd0;
            rd_len     <= 16'd0;
            blank_cnt  <= 16'd0;
            do_o       <= '0;
            de_o       <= 1'b0;
            hs_o       <= 1'b0;
            vs_o       <= 1'b0;
            line_len_o <= 16'd0;
        end else begin
            de_o <= (state == ST_ACTIVE);
            hs_o <= (state == ST_BLANK);
            do_o <= (state == ST_ACTIVE) ? mem[{rd_bank, rd_cnt[AW-1:0]}] : '0;
            vs_o <= vs_i & (state == ST_IDLE) & ~(|full);
            case (state)
                ST_IDLE: begin
                    if (rd_start) begin
                        rd_cnt     <= 16'd0;
                        rd_len     <= len[rd_bank];
                        line_len_o <= len[rd_bank];
                        state      <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    rd_cnt <= rd_cnt + 16'd1;
                    if (rd_done) begin
                        rd_bank   <= ~rd_bank;
                        blank_cnt <= 16'd0;
                        state     <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    blank_cnt <= blank_cnt + 16'd1;
                    if (blank_cnt == BLANK_LAST) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SCALER_OUT_RETIME_OVF_EN
    logic        vs_d;
    logic        line_drop;
    logic [15:0] drop_cnt;

    assign line_drop = line_close & (wr_full | line_bad);

    // Sticky per-frame overflow flag and saturating dropped-line count; a drop beats the frame clear
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d     <= 1'b0;
            ovf_o    <= 1'b0;
            drop_cnt <= 16'd0;
        end else begin
            vs_d <= vs_i;
            if (line_drop)          ovf_o <= 1'b1;
            else if (vs_i & ~vs_d)  ovf_o <= 1'b0;
            if (line_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    assign ovf_o = 1'b0;
`endif

endmodule
